if_prefetch_queue: RTL and testbench

//  Instruction-fetch front end between instruction memory (IM) and the pipeline's IF register.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/if_queue_fifo.sv | 68 ++++++
 rtl/if_prefetch_queue.sv | 115 +++++++++++
 tb/tb_if_prefetch_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Constants and types shared by the CPU front end.
// Holds the instruction-memory address width, the canonical NOP and the fetch state encoding.
package cpu_pkg;

    localparam int          IM_AW    = 10;
    localparam logic [31:0] NOP_WORD = 32'h4000_0009;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } fetch_state_e;

endpackage

// File: rtl/if_queue_fifo.sv
// Instruction queue storage for the fetch front end.
// Each entry is an instruction word plus its PC. A clear drops every entry and wins over push and pop.
module if_queue_fifo #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 10,
    parameter logic [31:0] NOP_WORD = 32'h4000_0009
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [31:0]              push_word,
    input  logic [AW-1:0]            push_pc,
    output logic [31:0]              head_word,
    output logic [AW-1:0]            head_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int IW = $clog2(DEPTH);

    logic [IW:0]     head_q, head_d;
    logic [IW:0]     tail_q, tail_d;
    logic [31:0]     word_q [DEPTH];
    logic [AW-1:0]   pc_q   [DEPTH];
    logic            do_push;
    logic            do_pop;

    // The extra top pointer bit separates a full queue from an empty one at the same index.
    assign empty   = (head_q == tail_q);
    assign full    = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
    assign count   = tail_q - head_q;
    assign do_push = push && !clear;
    assign do_pop  = pop && !empty && !clear;

    assign head_word = empty ? NOP_WORD : word_q[head_q[IW-1:0]];
    assign head_pc   = empty ? '0 : pc_q[head_q[IW-1:0]];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (clear) begin
            head_d = tail_q;
        end else begin
            if (do_push) tail_d = tail_q + (IW+1)'(1);
            if (do_pop)  head_d = head_q + (IW+1)'(1);
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(negedge clk) begin
        if (do_push) begin
            word_q[tail_q[IW-1:0]] <= push_word;
            pc_q[tail_q[IW-1:0]]   <= push_pc;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues IM reads and queues returned words.
// An epoch tag follows each read so that returns belonging to a redirected-away stream are dropped.
module if_prefetch_queue #(
    parameter int          AW       = cpu_pkg::IM_AW,
    parameter int          DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     IM_enable_fetch,
    output logic                     IM_enable_mem,
    output logic [AW-1:0]            IM_address,
    input  logic [31:0]              IM_data,
    input  logic                     redirect_valid,
    input  logic [AW-1:0]            redirect_pc,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [AW-1:0]            instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   queue_count
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   req_pc_q, req_pc_d;
    logic            epoch_q, epoch_d;
    logic            req_epoch_q, req_epoch_d;
    logic            inflight_q, inflight_d;

    logic [CW:0]     reserved;
    logic            issue;
    logic            push;
    logic            pop;
    logic            q_empty;
    logic            q_full;
    logic [31:0]     push_word;

    // Queue slots are claimed when a read is issued, so a return always has room.
    assign reserved = {1'b0, queue_count} + {{CW{1'b0}}, inflight_q};
    assign issue    = (state_q == S_RUN) && !redirect_valid && (reserved < (CW+1)'(DEPTH));

    assign IM_enable_fetch = issue;
    assign IM_enable_mem   = issue;
    assign IM_address      = pc_q;

    assign push      = inflight_q && (req_epoch_q == epoch_q);
    assign push_word = (IM_data == 32'd0) ? NOP_WORD : IM_data;
    assign instr_valid = !q_empty && !redirect_valid;
    assign pop       = instr_valid && instr_ready;

    if_queue_fifo #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NOP_WORD (NOP_WORD)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (redirect_valid),
        .push_word (push_word),
        .push_pc   (req_pc_q),
        .head_word (instr),
        .head_pc   (instr_pc),
        .count     (queue_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // A redirect discards the pending read by flipping the epoch and restarts fetch at the target.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        epoch_d     = epoch_q;
        req_epoch_d = req_epoch_q;
        inflight_d  = issue;
        case (state_q)
            S_IDLE:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            epoch_d    = ~epoch_q;
            inflight_d = 1'b0;
        end else if (issue) begin
            pc_d        = pc_q + AW'(1);
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios followed by random ready/redirect traffic.
// A stream-level scoreboard expects consecutive PCs from the last redirect target, with zero words shown as NOP.
module tb_if_prefetch_queue;

    localparam logic [31:0] NOP = 32'h4000_0009;

    logic          clk;
    logic          rst;
    logic          IM_enable_fetch;
    logic          IM_enable_mem;
    logic [9:0]    IM_address;
    logic [31:0]   IM_data;
    logic          redirect_valid;
    logic [9:0]    redirect_pc;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [9:0]    instr_pc;
    logic          instr_ready;
    logic [2:0]    queue_count;

    logic [31:0]   mem [1024];
    logic [9:0]    expPc;
    int            stallCount;
    int            checks;
    int            failures;

    if_prefetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .IM_enable_fetch (IM_enable_fetch),
        .IM_enable_mem   (IM_enable_mem),
        .IM_address      (IM_address),
        .IM_data         (IM_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .queue_count     (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data for a request appears after the edge that samples it.
    always @(negedge clk) begin
        if (IM_enable_mem) IM_data <= mem[IM_address];
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] expWord(input logic [9:0] a);
        logic [31:0] w;
        w = mem[a];
        return (w == 32'd0) ? NOP : w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the sampling edge, then score the handshake that will occur.
    task automatic applyStimulus(input logic rv, input logic [9:0] rpc, input logic rdy);
        @(posedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
        checkOutput("im_enable_mem", IM_enable_mem, IM_enable_fetch);
        checkOutput("count_bound", 32'(queue_count <= 3'd4), 1);
        if (queue_count == 3'd4) checkOutput("fetch_when_full", IM_enable_fetch, 0);
        if (queue_count == 3'd0) checkOutput("instr_when_empty", instr, NOP);
        if (rv) begin
            checkOutput("valid_in_redirect", instr_valid, 0);
            checkOutput("fetch_in_redirect", IM_enable_fetch, 0);
        end
        if (instr_valid && rdy) begin
            checkOutput("instr_pc", instr_pc, expPc);
            checkOutput("instr", instr, expWord(expPc));
            expPc++;
            stallCount = 0;
        end else if (rdy && !rv) begin
            stallCount++;
        end else begin
            stallCount = 0;
        end
        checkOutput("stall", 32'(stallCount <= 4), 1);
        if (rv) begin
            expPc      = rpc;
            stallCount = 0;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_fetch"}, IM_enable_fetch, 0);
        checkOutput({tag, "_mem"}, IM_enable_mem, 0);
        checkOutput({tag, "_addr"}, IM_address, 0);
        checkOutput({tag, "_valid"}, instr_valid, 0);
        checkOutput({tag, "_instr"}, instr, NOP);
        checkOutput({tag, "_pc"}, instr_pc, 0);
        checkOutput({tag, "_count"}, queue_count, 0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        expPc          = '0;
        stallCount     = 0;
        IM_data        = '0;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = 32'(a) + 32'd100;
        for (int a = 64; a < 1020; a++) begin
            if ($urandom_range(0, 7) == 0) mem[a] = 32'd0;
            else mem[a] = $urandom;
        end
        mem[5] = 32'd0;

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        rst = 1'b1;

        $display("[TB] streaming start-up");
        applyStimulus(0, 0, 1);
        checkOutput("t1_addr0", IM_address, 0);
        checkOutput("t1_fetch0", IM_enable_fetch, 1);
        checkOutput("t1_valid_e1", instr_valid, 0);
        applyStimulus(0, 0, 1);
        checkOutput("t1_addr1", IM_address, 1);
        checkOutput("t1_valid_e2", instr_valid, 0);
        applyStimulus(0, 0, 1);
        checkOutput("t1_valid_e3", instr_valid, 1);
        checkOutput("t1_first_instr", instr, 100);
        applyStimulus(0, 0, 1);
        checkOutput("t1_second_instr", instr, 101);
        repeat (6) applyStimulus(0, 0, 1);

        $display("[TB] back-pressure");
        repeat (10) applyStimulus(0, 0, 0);
        checkOutput("t2_count_full", queue_count, 4);
        checkOutput("t2_fetch_full", IM_enable_fetch, 0);
        repeat (12) applyStimulus(0, 0, 1);

        $display("[TB] redirect with queued entries");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0);
            if (queue_count == 3'd3) break;
        end
        checkOutput("t4_fill3", queue_count, 3);
        applyStimulus(1, 10'd40, 1);
        checkOutput("t4_valid_redirect", instr_valid, 0);
        applyStimulus(0, 0, 1);
        checkOutput("t4_count_cleared", queue_count, 0);
        checkOutput("t4_fetch_target", IM_address, 40);
        checkOutput("t4_fetch_en", IM_enable_fetch, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("t4_first_pc", instr_pc, 40);
        applyStimulus(0, 0, 1);
        checkOutput("t4_second_pc", instr_pc, 41);
        repeat (4) applyStimulus(0, 0, 1);

        $display("[TB] address wrap and double redirect");
        applyStimulus(1, 10'd1022, 1);
        applyStimulus(0, 0, 1);
        checkOutput("t5_addr1022", IM_address, 1022);
        applyStimulus(0, 0, 1);
        checkOutput("t5_addr1023", IM_address, 1023);
        applyStimulus(0, 0, 1);
        checkOutput("t5_addr_wrap", IM_address, 0);
        repeat (6) applyStimulus(0, 0, 1);
        applyStimulus(1, 10'd7, 1);
        applyStimulus(1, 10'd9, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("t5_last_redirect_valid", instr_valid, 1);
        checkOutput("t5_last_redirect_pc", instr_pc, 9);
        repeat (4) applyStimulus(0, 0, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic rv;
            logic rdy;
            rv  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            applyStimulus(rv, 10'($urandom_range(0, 1023)), rdy);
        end
        repeat (8) applyStimulus(0, 0, 1);

        $display("[TB] reset mid-stream");
        applyStimulus(1, 10'd300, 1);
        repeat (3) applyStimulus(0, 0, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(posedge clk);
        redirect_valid = 1'b0;
        rst            = 1'b1;
        expPc          = '0;
        stallCount     = 0;
        applyStimulus(0, 0, 1);
        checkOutput("t6_restart_addr", IM_address, 0);
        checkOutput("t6_restart_fetch", IM_enable_fetch, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("t6_first_pc", instr_pc, 0);
        checkOutput("t6_first_instr", instr, 100);
        repeat (8) applyStimulus(0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
